// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: emits a captured bit pattern MSB-first,
// optionally repeated with an idle gap, behind a start/busy/done handshake.
module seq_pattern_tx #(
    parameter int               PAT_W       = 5,
    parameter logic [PAT_W-1:0] PAT_DEFAULT = 5'b10010,
    parameter int               LEN_W       = 3,
    parameter int               RPT_W       = 4,
    parameter int               GAP_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             start_dflt,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [LEN_W-1:0] pat_len,
    input  logic [RPT_W-1:0] rpt,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
    localparam logic [RPT_W-1:0] RPT_ONE = RPT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

    state_t           state, state_n;
    logic [PAT_W-1:0] pat_q, pat_n;
    logic [LEN_W-1:0] len_q, len_n;
    logic [LEN_W-1:0] idx_q, idx_n;
    logic [RPT_W-1:0] rem_q, rem_n;
    logic [GAP_W-1:0] gap_q, gap_n;
    logic [GAP_W-1:0] gcnt_q, gcnt_n;
    logic             out_n, vld_n, busy_n, done_n;

    logic [PAT_W-1:0] p_in;
    logic [LEN_W-1:0] l_in;
    logic [RPT_W-1:0] r_in;

    // Effective request values, resolved once at acceptance
    always_comb begin
        p_in = start_dflt ? PAT_DEFAULT : pat_in;
        l_in = pat_len;
        if (start_dflt || pat_len == '0 || pat_len > LEN_MAX)
            l_in = LEN_MAX;
        r_in = (rpt == '0) ? RPT_ONE : rpt;
    end

    always_comb begin
        state_n = state;
        pat_n   = pat_q;
        len_n   = len_q;
        idx_n   = idx_q;
        rem_n   = rem_q;
        gap_n   = gap_q;
        gcnt_n  = gcnt_q;
        out_n   = 1'b0;
        vld_n   = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    pat_n   = p_in;
                    len_n   = l_in;
                    rem_n   = r_in;
                    gap_n   = gap;
                    gcnt_n  = '0;
                    idx_n   = l_in - LEN_ONE;
                    out_n   = p_in[idx_n];
                    vld_n   = 1'b1;
                    busy_n  = 1'b1;
                    state_n = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else if (idx_q != '0) begin
                    idx_n  = idx_q - LEN_ONE;
                    out_n  = pat_q[idx_n];
                    vld_n  = 1'b1;
                    busy_n = 1'b1;
                end else if (rem_q > RPT_ONE) begin
                    rem_n  = rem_q - RPT_ONE;
                    busy_n = 1'b1;
                    if (gap_q != '0) begin
                        gcnt_n  = gap_q;
                        state_n = S_GAP;
                    end else begin
                        idx_n = len_q - LEN_ONE;
                        out_n = pat_q[idx_n];
                        vld_n = 1'b1;
                    end
                end else begin
                    done_n  = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else begin
                    busy_n = 1'b1;
                    // gcnt holds the idle cycles still to show, this one included
                    if (gcnt_q == GAP_ONE) begin
                        gcnt_n  = '0;
                        idx_n   = len_q - LEN_ONE;
                        out_n   = pat_q[idx_n];
                        vld_n   = 1'b1;
                        state_n = S_SHIFT;
                    end else begin
                        gcnt_n = gcnt_q - GAP_ONE;
                    end
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            rem_q     <= '0;
            gap_q     <= '0;
            gcnt_q    <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            pat_q     <= pat_n;
            len_q     <= len_n;
            idx_q     <= idx_n;
            rem_q     <= rem_n;
            gap_q     <= gap_n;
            gcnt_q    <= gcnt_n;
            ser_out   <= out_n;
            ser_valid <= vld_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed and random transactions checked
// cycle by cycle against a per-transaction expected output stream.
module tb_seq_pattern_tx;

    logic       clk;
    logic       rst;
    logic       start;
    logic       start_dflt;
    logic [4:0] pat_in;
    logic [2:0] pat_len;
    logic [3:0] rpt;
    logic [3:0] gap;
    logic       abort;
    logic       ser_out;
    logic       ser_valid;
    logic       busy;
    logic       done;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    seq_pattern_tx dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_dflt(start_dflt),
        .pat_in    (pat_in),
        .pat_len   (pat_len),
        .rpt       (rpt),
        .gap       (gap),
        .abort     (abort),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observation word: {ser_valid, ser_out, busy, done}
    task automatic check(input string tag, input logic [3:0] e);
        logic [3:0] o;
        o = {ser_valid, ser_out, busy, done};
        total++;
        assert (o === e) passed++;
        else begin
            failed++;
            $error("FAIL %s: got v/bit/busy/done=%b expected %b", tag, o, e);
        end
    endtask

    task automatic run(input string name, input bit dflt, input logic [4:0] p,
                       input logic [2:0] ln, input logic [3:0] r,
                       input logic [3:0] g, input int abort_at,
                       input int rst_at, input bit noise, input bit abort_w_start);
        logic [3:0] q[$];
        logic [4:0] pat;
        int L, R, done_cyc;
        pat = dflt ? 5'b10010 : p;
        L = (dflt || ln == 0 || ln > 5) ? 5 : int'(ln);
        R = (r == 0) ? 1 : int'(r);
        for (int k = 0; k < R; k++) begin
            for (int i = L - 1; i >= 0; i--) q.push_back({1'b1, pat[i], 1'b1, 1'b0});
            if (k < R - 1)
                for (int j = 0; j < int'(g); j++) q.push_back(4'b0010);
        end
        done_cyc = q.size() + 1;
        q.push_back(4'b0001);
        q.push_back(4'b0000);
        if (abort_at > 0 && abort_at < done_cyc) begin
            q = q[0:abort_at-1];
            q.push_back(4'b0000);
            q.push_back(4'b0000);
        end
        if (rst_at > 0 && rst_at < done_cyc) begin
            q = q[0:rst_at-1];
            q.push_back(4'b0000);
            q.push_back(4'b0000);
        end

        @(negedge clk);
        start_dflt = dflt;
        pat_in     = p;
        pat_len    = ln;
        rpt        = r;
        gap        = g;
        start      = 1'b1;
        abort      = abort_w_start;
        for (int c = 1; c <= q.size(); c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            rst   = 1'b1;
            check($sformatf("%s c%0d", name, c), q[c-1]);
            if (noise) begin
                pat_in     = 5'($urandom);
                pat_len    = 3'($urandom);
                rpt        = 4'($urandom);
                gap        = 4'($urandom);
                start_dflt = 1'($urandom);
                if (c == 2 || (c == 6 && c < done_cyc) || c == done_cyc) start = 1'b1;
            end
            if (c == abort_at) abort = 1'b1;
            if (c == rst_at) rst = 1'b0;
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b1;
    endtask

    initial begin
        int ab;
        rst        = 1'b0;
        start      = 1'b0;
        start_dflt = 1'b0;
        pat_in     = '0;
        pat_len    = '0;
        rpt        = '0;
        gap        = '0;
        abort      = 1'b0;
        repeat (3) @(negedge clk);
        check("reset", 4'b0000);
        rst = 1'b1;
        @(negedge clk);
        check("idle", 4'b0000);

        run("dflt",      1, 5'b00000, 3'd0, 4'd0,  4'd0,  0, 0, 0, 0);
        run("short",     0, 5'b00101, 3'd3, 4'd1,  4'd0,  0, 0, 0, 0);
        run("rpt_gap",   1, 5'b00000, 3'd0, 4'd2,  4'd3,  0, 0, 0, 0);
        run("b2b",       1, 5'b00000, 3'd0, 4'd3,  4'd0,  0, 0, 0, 0);
        run("ign_start", 1, 5'b00000, 3'd0, 4'd2,  4'd2,  0, 0, 1, 0);
        run("abort",     1, 5'b00000, 3'd0, 4'd1,  4'd0,  3, 0, 0, 0);
        run("rst_mid",   1, 5'b00000, 3'd0, 4'd1,  4'd0,  0, 3, 0, 0);
        run("after",     0, 5'b11010, 3'd4, 4'd2,  4'd1,  0, 0, 0, 0);
        run("abort_st",  0, 5'b10110, 3'd5, 4'd1,  4'd0,  0, 0, 0, 1);
        run("abort_gap", 1, 5'b00000, 3'd0, 4'd3,  4'd4,  7, 0, 0, 0);
        run("abort_dn",  0, 5'b00011, 3'd2, 4'd1,  4'd0,  3, 0, 0, 0);
        run("len7",      0, 5'b01101, 3'd7, 4'd1,  4'd0,  0, 0, 0, 0);
        run("len0",      0, 5'b10011, 3'd0, 4'd1,  4'd0,  0, 0, 0, 0);
        run("max",       0, 5'b00001, 3'd1, 4'd15, 4'd15, 0, 0, 1, 0);

        for (int t = 0; t < 25; t++) begin
            ab = ($urandom % 3 == 0) ? int'($urandom_range(1, 40)) : 0;
            run($sformatf("rnd%0d", t), 1'($urandom % 4 == 0), 5'($urandom),
                3'($urandom), 4'($urandom % 6), 4'($urandom % 5),
                ab, 0, ab == 0, 1'($urandom % 8 == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial bit-pattern transmitter. It is the generating end of the team's serial sequence-detection path: it emits a programmable pattern (default 10010) MSB-first, one bit per clock. The pattern can be repeated a programmed number of times, with a programmable idle gap between repetitions. It drives detector blocks and bench stimulus, and it exposes a start/busy/done handshake to the controlling logic.

Parameters:
PAT_W, 5, maximum pattern length in bits
PAT_DEFAULT, 5'b10010, pattern used when start_dflt is asserted
LEN_W, 3, width of pat_len (must satisfy 2^LEN_W > PAT_W)
RPT_W, 4, width of repeat count
GAP_W, 4, width of inter-repeat gap count

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low
start  in  1  request; sampled only in IDLE
start_dflt  in  1  when high together with start, use PAT_DEFAULT and length PAT_W instead of pat_in/pat_len
pat_in  in  PAT_W  pattern; the active bits are the low pat_len bits
pat_len  in  LEN_W  active length; 0 or >PAT_W means PAT_W
rpt  in  RPT_W  number of transmissions; 0 means 1
gap  in  GAP_W  idle cycles between transmissions
abort  in  1  cancel the current operation
ser_out  out  1  serial data, registered
ser_valid  out  1  ser_out carries a pattern bit this cycle
busy  out  1  high from the cycle after acceptance through the last bit
done  out  1  one-cycle pulse after normal completion

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE; ser_out=0, ser_valid=0, busy=0, done=0; all internal counters and registers cleared. Reset wins over every other input, including mid-transmission.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - On start=1, capture pattern, effective length L, effective repeat R and gap G. Go to SHIFT.
  - In the same edge, drive ser_out=pattern[L-1], ser_valid=1, busy=1. The first bit is therefore visible in the cycle after start is sampled (latency 1).
- SHIFT:
  - Each cycle, emit the next lower bit: index L-1 down to 0.
  - After bit 0:
    - More repetitions remain and G>0: go to GAP.
    - More repetitions remain and G=0: restart at bit L-1 in the next cycle (back-to-back, no bubble).
    - Otherwise: go to DONE.
- GAP: exactly G cycles with ser_valid=0, ser_out=0, busy=1. Then SHIFT restarts at bit L-1.
- DONE: lasts one cycle; done=1, busy=0, ser_valid=0, ser_out=0. Returns to IDLE unconditionally.
- Start rules:
  - start is ignored in SHIFT, GAP and DONE; it is never queued.
  - Inputs pat_in, pat_len, rpt and gap are only sampled at acceptance; later changes have no effect.
- Whenever ser_valid=0, ser_out=0.
- abort=1 in SHIFT or GAP: next state IDLE, with ser_valid=0, busy=0. No done pulse. abort in IDLE/DONE has no effect. abort and start in the same IDLE cycle: start is accepted and abort is ignored.
- Counters:
  - Bit index counter: LEN_W bits; it never wraps below 0.
  - Repeat counter: RPT_W bits, counting down from R.
  - Gap counter: GAP_W bits.
  - Maximum-value repeat and gap (all ones) must work without overflow.
- Total busy cycles = R*L + (R-1)*G. done asserts the cycle after the last bit.

Test Plan:
- Default pattern: start=1, start_dflt=1, rpt=0, gap=0 -> ser_out 1,0,0,1,0 on cycles 1..5 with ser_valid=1; done=1 on cycle 6 only; busy=1 on cycles 1..5.
- Short pattern: pat_in=5'b00101, pat_len=3, rpt=1 -> ser_out 1,0,1 on cycles 1..3; done on cycle 4.
- Repeat with gap: default pattern, rpt=2, gap=3 -> 10010, three cycles of ser_valid=0, 10010; busy for 13 cycles; done on cycle 14.
- Back-to-back: rpt=3, gap=0 -> 15 consecutive valid bits 100101001010010; done on cycle 16.
- start pulsed on cycles 2 and 6 of a running transmission, and again during the done cycle -> all three are ignored; output stream is unchanged; only one done pulse occurs.
- abort on cycle 3, and separately rst=0 on cycle 3 -> in both cases, from cycle 4: ser_valid=0, busy=0, no done. A new start is then accepted normally.
